// File: rtl/element_wise_vec_if.sv
// Beat-level handshake bundle for element_wise_vec: operands, per-beat controls,
// result channel and sticky overflow status.
interface element_wise_vec_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4
);
  logic [LANES*DATA_W-1:0] operand_a;
  logic [LANES*DATA_W-1:0] operand_b;
  logic [3:0]              op_type;
  logic                    sat_en;
  logic                    bcast_b;
  logic [LANES-1:0]        lane_mask;
  logic                    valid_in;
  logic                    ready_in;
  logic [LANES*DATA_W-1:0] data_out;
  logic [LANES-1:0]        ovf_out;
  logic                    err_out;
  logic                    valid_out;
  logic                    ready_out;
  logic [LANES-1:0]        ovf_sticky;
  logic                    clear_sticky;

  // master drives beats and consumes results; slave is the vector unit
  modport master (
    output operand_a, operand_b, op_type, sat_en, bcast_b, lane_mask, valid_in,
    output ready_out, clear_sticky,
    input  ready_in, data_out, ovf_out, err_out, valid_out, ovf_sticky
  );

  modport slave (
    input  operand_a, operand_b, op_type, sat_en, bcast_b, lane_mask, valid_in,
    input  ready_out, clear_sticky,
    output ready_in, data_out, ovf_out, err_out, valid_out, ovf_sticky
  );
endinterface

// File: rtl/element_wise_vec.sv
// Two-stage element-wise signed vector ALU: S1 holds the accepted beat, S2 holds
// the computed result; per-lane saturation/wrap, masking, broadcast and sticky overflow.
module element_wise_vec #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  element_wise_vec_if.slave bus
);
  localparam int WW = 2 * DATA_W;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_MAX  = 4'd3;
  localparam logic [3:0] OP_MIN  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_RELU = 4'd8;
  localparam logic [3:0] OP_ABS  = 4'd9;
  localparam logic [3:0] OP_PASS = 4'd10;

  localparam logic signed [WW-1:0] MAX_X = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [WW-1:0] MIN_X = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]    MAX_W = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]    MIN_W = {1'b1, {(DATA_W-1){1'b0}}};

  logic                    s1_valid_reg;
  logic [LANES*DATA_W-1:0] s1_a_reg;
  logic [LANES*DATA_W-1:0] s1_b_reg;
  logic [3:0]              s1_op_reg;
  logic                    s1_sat_reg;
  logic                    s1_bcast_reg;
  logic [LANES-1:0]        s1_mask_reg;

  logic                    s2_valid_reg;
  logic [LANES*DATA_W-1:0] s2_data_reg;
  logic [LANES-1:0]        s2_ovf_reg;
  logic                    s2_err_reg;
  logic [LANES-1:0]        ovf_sticky_reg;

  logic                    s1_load;
  logic                    s2_load;
  logic                    xfer;
  logic [LANES*DATA_W-1:0] data_next;
  logic [LANES-1:0]        ovf_next;
  logic                    err_next;

  assign s2_load  = !s2_valid_reg || bus.ready_out;
  assign s1_load  = !s1_valid_reg || s2_load;
  assign xfer     = s2_valid_reg && bus.ready_out;
  assign err_next = (s1_op_reg > OP_PASS);

  assign bus.ready_in   = s1_load;
  assign bus.valid_out  = s2_valid_reg;
  assign bus.data_out   = s2_data_reg;
  assign bus.ovf_out    = s2_ovf_reg;
  assign bus.err_out    = s2_err_reg;
  assign bus.ovf_sticky = ovf_sticky_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_op_reg    <= '0;
      s1_sat_reg   <= 1'b0;
      s1_bcast_reg <= 1'b0;
      s1_mask_reg  <= '0;
    end else if (s1_load) begin
      s1_valid_reg <= bus.valid_in;
      if (bus.valid_in) begin
        s1_a_reg     <= bus.operand_a;
        s1_b_reg     <= bus.operand_b;
        s1_op_reg    <= bus.op_type;
        s1_sat_reg   <= bus.sat_en;
        s1_bcast_reg <= bus.bcast_b;
        s1_mask_reg  <= bus.lane_mask;
      end
    end
  end

  // Result registers only change when a real beat moves in, so a stalled beat holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
      s2_ovf_reg   <= '0;
      s2_err_reg   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_data_reg <= data_next;
        s2_ovf_reg  <= ovf_next;
        s2_err_reg  <= err_next;
      end
    end
  end

  // A transfer's overflow bits are ORed in after the clear, so set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky_reg <= '0;
    end else begin
      ovf_sticky_reg <= (bus.clear_sticky ? '0 : ovf_sticky_reg)
                      | (xfer ? s2_ovf_reg : '0);
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [DATA_W-1:0] a_l;
    logic signed [DATA_W-1:0] b_l;
    logic signed [WW-1:0]     a_x;
    logic signed [WW-1:0]     b_x;
    logic signed [WW-1:0]     exact;
    logic                     arith;
    logic                     ovf_l;
    logic [DATA_W-1:0]        res_l;

    assign a_l = s1_a_reg[gi*DATA_W +: DATA_W];
    assign b_l = s1_bcast_reg ? s1_b_reg[DATA_W-1:0] : s1_b_reg[gi*DATA_W +: DATA_W];
    assign a_x = {{DATA_W{a_l[DATA_W-1]}}, a_l};
    assign b_x = {{DATA_W{b_l[DATA_W-1]}}, b_l};

    // Arithmetic ops are evaluated at double width so the exact result is visible.
    always_comb begin
      exact = '0;
      arith = 1'b0;
      res_l = '0;
      case (s1_op_reg)
        OP_ADD:  begin exact = a_x + b_x; arith = 1'b1; end
        OP_SUB:  begin exact = a_x - b_x; arith = 1'b1; end
        OP_MUL:  begin exact = a_x * b_x; arith = 1'b1; end
        OP_ABS:  begin exact = a_x[WW-1] ? -a_x : a_x; arith = 1'b1; end
        OP_MAX:  res_l = (a_l > b_l) ? a_l : b_l;
        OP_MIN:  res_l = (a_l < b_l) ? a_l : b_l;
        OP_AND:  res_l = a_l & b_l;
        OP_OR:   res_l = a_l | b_l;
        OP_XOR:  res_l = a_l ^ b_l;
        OP_RELU: res_l = a_l[DATA_W-1] ? '0 : a_l;
        OP_PASS: res_l = a_l;
        default: res_l = '0;
      endcase
      ovf_l = arith && ((exact > MAX_X) || (exact < MIN_X));
      if (arith) begin
        if (ovf_l && s1_sat_reg) res_l = exact[WW-1] ? MIN_W : MAX_W;
        else                     res_l = exact[DATA_W-1:0];
      end
    end

    assign data_next[gi*DATA_W +: DATA_W] = err_next          ? '0 :
                                            s1_mask_reg[gi]   ? res_l : a_l;
    assign ovf_next[gi] = !err_next && s1_mask_reg[gi] && ovf_l;
  end
endmodule

// File: tb/tb_element_wise_vec.sv
// Directed and randomized checks of element_wise_vec against a queue-based
// beat model computed with plain integer arithmetic.
module tb_element_wise_vec;
  localparam int W = 16;
  localparam int L = 4;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  ovf;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  element_wise_vec_if #(.DATA_W(W), .LANES(L)) bus ();
  element_wise_vec #(.DATA_W(W), .LANES(L)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          tests = 0;
  int          fails = 0;
  exp_t        q[$];
  logic [3:0]  sticky_m = '0;
  logic [63:0] last_data;
  logic [3:0]  last_ovf;
  logic        last_err;
  bit          stall_prev = 0;
  logic [63:0] stall_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic exp_t ref_beat(logic [63:0] a, logic [63:0] b, logic [3:0] op,
                                    logic sat, logic bc, logic [3:0] m);
    exp_t r;
    logic signed [15:0] sa, sb;
    longint av, bv, x;
    r.data = '0; r.ovf = '0; r.err = (op > 4'd10);
    if (r.err) return r;
    for (int i = 0; i < L; i++) begin
      sa = a[i*W +: W];
      sb = bc ? b[W-1:0] : b[i*W +: W];
      av = sa; bv = sb;
      if (!m[i]) begin r.data[i*W +: W] = sa; continue; end
      case (op)
        4'd0: x = av + bv;
        4'd1: x = av - bv;
        4'd2: x = av * bv;
        4'd3: x = (av > bv) ? av : bv;
        4'd4: x = (av < bv) ? av : bv;
        4'd5: x = av & bv;
        4'd6: x = av | bv;
        4'd7: x = av ^ bv;
        4'd8: x = (av < 0) ? 0 : av;
        4'd9: x = (av < 0) ? -av : av;
        default: x = av;
      endcase
      if (x > 32767) begin
        r.ovf[i] = 1'b1;
        if (sat) x = 32767;
      end else if (x < -32768) begin
        r.ovf[i] = 1'b1;
        if (sat) x = -32768;
      end
      r.data[i*W +: W] = x[15:0];
    end
    return r;
  endfunction

  // One clock cycle: inputs already driven; sample at negedge+1, update model, advance.
  task automatic tick(output bit acc);
    exp_t e;
    bit   xfr;
    #1;
    if (!rst) chk("ready_in", bus.ready_in, (q.size() < 2) || bus.ready_out);
    if (stall_prev && !rst) chk("stall_hold", bus.data_out, stall_data);
    acc = !rst && bus.valid_in && bus.ready_in;
    xfr = !rst && bus.valid_out && bus.ready_out;
    e.ovf = '0;
    if (xfr) begin
      if (q.size() == 0) begin
        chk("spurious_beat", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("data_out", bus.data_out, e.data);
        chk("ovf_out", bus.ovf_out, e.ovf);
        chk("err_out", bus.err_out, e.err);
        last_data = bus.data_out; last_ovf = bus.ovf_out; last_err = bus.err_out;
        $display("[TB] beat out data=%h ovf=%b err=%b", bus.data_out, bus.ovf_out, bus.err_out);
      end
    end
    sticky_m   = (bus.clear_sticky ? 4'b0 : sticky_m) | (xfr ? e.ovf : 4'b0);
    stall_prev = !rst && bus.valid_out && !bus.ready_out;
    stall_data = bus.data_out;
    if (acc) q.push_back(ref_beat(bus.operand_a, bus.operand_b, bus.op_type,
                                  bus.sat_en, bus.bcast_b, bus.lane_mask));
    @(posedge clk);
    @(negedge clk);
    if (rst) begin
      q.delete();
      sticky_m   = '0;
      stall_prev = 0;
    end
    chk("ovf_sticky", bus.ovf_sticky, sticky_m);
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                      input logic sat, input logic bc, input logic [3:0] m);
    bit acc = 0;
    bus.operand_a = a; bus.operand_b = b; bus.op_type = op;
    bus.sat_en = sat; bus.bcast_b = bc; bus.lane_mask = m; bus.valid_in = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) tick(acc);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    bus.valid_in = 1'b0;
  endtask

  task automatic flush();
    bit acc;
    bus.valid_in = 1'b0; bus.ready_out = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) tick(acc);
    chk("drain", q.size(), 0);
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: rnd16 = 16'h7FFF;
      1: rnd16 = 16'h8000;
      2: rnd16 = 16'hFFFF;
      3: rnd16 = 16'h0001;
      default: rnd16 = 16'($urandom);
    endcase
  endfunction

  initial begin
    bit acc;
    int idx;
    logic [63:0] ra, rb;

    rst = 1'b1;
    bus.operand_a = '0; bus.operand_b = '0; bus.op_type = '0; bus.sat_en = 1'b0;
    bus.bcast_b = 1'b0; bus.lane_mask = '1; bus.valid_in = 1'b0;
    bus.ready_out = 1'b1; bus.clear_sticky = 1'b0;
    @(negedge clk);
    tick(acc); tick(acc);
    rst = 1'b0;
    chk("rst_valid_out", bus.valid_out, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_ovf_out", bus.ovf_out, 0);
    chk("rst_err_out", bus.err_out, 0);
    chk("rst_sticky", bus.ovf_sticky, 0);
    #1 chk("rst_ready_in", bus.ready_in, 1);

    // Latency: valid_out rises two cycles after acceptance
    send(64'h0001_0002_0003_7FFF, 64'h0001_0001_0001_0001, 4'd0, 1'b0, 1'b0, 4'hF);
    chk("lat_s1_only", bus.valid_out, 0);
    tick(acc);
    chk("lat_valid_out", bus.valid_out, 1);
    flush();
    chk("add_wrap_data", last_data[15:0], 16'h8000);
    chk("add_wrap_ovf", last_ovf[0], 1);

    bus.clear_sticky = 1'b1; tick(acc); bus.clear_sticky = 1'b0;
    chk("clear_sticky", bus.ovf_sticky, 0);

    send(64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_0001, 4'd0, 1'b1, 1'b0, 4'hF);
    flush();
    chk("add_sat_data", last_data[15:0], 16'h7FFF);
    chk("add_sat_ovf", last_ovf[0], 1);
    chk("add_sat_sticky", bus.ovf_sticky[0], 1);

    send(64'h0000_0000_FFFD_0100, 64'h0000_0000_0005_0100, 4'd2, 1'b1, 1'b0, 4'hF);
    flush();
    chk("mul_sat_lane0", last_data[15:0], 16'h7FFF);
    chk("mul_lane1", last_data[31:16], 16'hFFF1);
    chk("mul_ovf", last_ovf[1:0], 2'b01);

    send(64'h0000_0000_0000_8000, 64'h0, 4'd9, 1'b1, 1'b0, 4'hF);
    flush();
    chk("abs_sat", last_data[15:0], 16'h7FFF);
    chk("abs_ovf", last_ovf[0], 1);

    send(64'h0004_0003_0002_0001, 64'h0003_0002_0001_0009, 4'd0, 1'b0, 1'b1, 4'b1011);
    flush();
    chk("bcast_mask_data", last_data, 64'h000D_0003_000B_000A);
    chk("bcast_mask_ovf", last_ovf, 0);

    send(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 4'd12, 1'b0, 1'b0, 4'hF);
    flush();
    chk("illegal_data", last_data, 0);
    chk("illegal_err", last_err, 1);

    // Back-to-back beats with a three-cycle downstream stall
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      bus.ready_out = (c < 2 || c > 4);
      bus.valid_in  = (idx < 4);
      bus.operand_a = {4{16'(idx * 100)}};
      bus.operand_b = {4{16'(idx + 1)}};
      bus.op_type = 4'd1; bus.sat_en = 1'b0; bus.bcast_b = 1'b0; bus.lane_mask = 4'hF;
      if (c == 2) #1 chk("stall_ready_low", bus.ready_in, 0);
      tick(acc);
      if (acc) idx++;
    end
    chk("b2b_all_sent", idx, 4);
    flush();

    // Reset with two beats in flight
    bus.ready_out = 1'b0;
    send(64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 4'd0, 1'b0, 1'b0, 4'hF);
    send(64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 4'd0, 1'b0, 1'b0, 4'hF);
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    chk("rst_flight_valid", bus.valid_out, 0);
    chk("rst_flight_sticky", bus.ovf_sticky, 0);
    chk("rst_flight_data", bus.data_out, 0);
    #1 chk("rst_flight_ready", bus.ready_in, 1);
    bus.ready_out = 1'b1;
    tick(acc); tick(acc);
    chk("rst_no_ghost", bus.valid_out, 0);

    // Randomized traffic with random stalls and sticky clears
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < L; i++) begin
        ra[i*W +: W] = rnd16();
        rb[i*W +: W] = rnd16();
      end
      bus.operand_a    = ra;
      bus.operand_b    = rb;
      bus.op_type      = 4'($urandom_range(0, 15));
      bus.sat_en       = 1'($urandom);
      bus.bcast_b      = ($urandom_range(0, 3) == 0);
      bus.lane_mask    = 4'($urandom);
      bus.valid_in     = ($urandom_range(0, 3) != 0);
      bus.ready_out    = ($urandom_range(0, 3) != 0);
      bus.clear_sticky = ($urandom_range(0, 15) == 0);
      tick(acc);
    end
    bus.clear_sticky = 1'b0;
    flush();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
